// File: rtl/ddr3_cpu_req_queue.sv
// CPU-side request queue for the DDR3 controller. It is a show-ahead FIFO of
// {cmd, bank, addr, write data, mask} entries with a registered occupancy
// count and a sticky overflow flag for requests offered while full.
module ddr3_cpu_req_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CPU_CLK,
    input  logic                       RESET_N,
    input  logic                       ADDR_VALID,
    input  logic                       CMD,
    input  logic [2:0]                 BA,
    input  logic [14:0]                ADDR,
    input  logic [63:0]                WR_DATA,
    input  logic [7:0]                 DM,
    output logic                       CMD_RDY,
    output logic                       Q_VALID,
    output logic                       Q_CMD,
    output logic [2:0]                 Q_BA,
    output logic [14:0]                Q_ADDR,
    output logic [63:0]                Q_WR_DATA,
    output logic [7:0]                 Q_DM,
    input  logic                       Q_ACCEPT,
    output logic [$clog2(DEPTH):0]     Q_COUNT,
    output logic                       OVERFLOW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 1 + 3 + 15 + 64 + 8;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] entry_d;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          push;
    logic          pop;

    // Ready/valid come straight from the registered count; no pop look-through.
    always_comb begin
        CMD_RDY = (count_q < DEPTH_C);
        Q_VALID = (count_q != '0);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        entry_d = {CMD, BA, ADDR, WR_DATA, DM};
        push    = ADDR_VALID & CMD_RDY & RESET_N;
        pop     = Q_ACCEPT & Q_VALID & RESET_N;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q | (ADDR_VALID & ~CMD_RDY);
        if (push) begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge CPU_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage is never reset; it is only visible while Q_VALID is high.
    always_ff @(posedge CPU_CLK) begin
        if (push) begin
            mem_q[tail_q] <= entry_d;
        end
    end

    // Show-ahead head entry and status outputs.
    always_comb begin
        {Q_CMD, Q_BA, Q_ADDR, Q_WR_DATA, Q_DM} = mem_q[head_q];
        Q_COUNT  = count_q;
        OVERFLOW = ovf_q;
    end

endmodule
